hazard_scoreboard_unit: RTL and testbench

//  Scoreboard-based hazard detector for the in-order MIPS-lite pipeline; replaces the fixed lw/branch stall checks.
//  Per-register countdown of cycles until a pending result is forwardable; stalls the ID stage until every source is ready.

---
 rtl/hazard_scoreboard_unit_pkg.sv | 12 +
 rtl/hazard_scoreboard_unit_sb_entry.sv | 35 +++
 rtl/hazard_scoreboard_unit.sv | 94 +++++++++
 tb/tb_hazard_scoreboard_unit.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_unit_pkg.sv
// hazard_scoreboard_unit_pkg: shared widths, default latencies and a saturating counter helper
package hazard_scoreboard_unit_pkg;
    localparam int HAZ_REG_AW   = 5;
    localparam int HAZ_CNT_W    = 3;
    localparam int HAZ_ALU_LAT  = 1;
    localparam int HAZ_LOAD_LAT = 2;
    localparam logic [4:0] HAZ_ZERO_REG = 5'd0;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != '1) ? v + 32'd1 : v;
    endfunction
endpackage

// File: rtl/hazard_scoreboard_unit_sb_entry.sv
// hazard_scoreboard_unit_sb_entry: one register's countdown until its pending result is forwardable
module hazard_scoreboard_unit_sb_entry
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int CNT_W    = HAZ_CNT_W,
    parameter int ALU_LAT  = HAZ_ALU_LAT,
    parameter int LOAD_LAT = HAZ_LOAD_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic hold_i,
    input  logic wr_i,
    input  logic is_load_i,
    output logic rdy_alu_o,
    output logic rdy_br_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // a new producer overrides the decrement so the newest writer wins
    always_comb begin
        cnt_d = hold_i ? cnt_q
              : wr_i   ? (is_load_i ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT))
              : (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    end

    // counter register, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // branches compare in ID so need a settled value; ALU ops can take EX forwarding one cycle early
    assign rdy_br_o  = cnt_q == '0;
    assign rdy_alu_o = cnt_q <= CNT_W'(1);
endmodule

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: scoreboard stall/issue control for ID; HAZ_PERF_SPLIT_EN adds split stall counters
module hazard_scoreboard_unit
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int REG_AW   = HAZ_REG_AW,
    parameter int ALU_LAT  = HAZ_ALU_LAT,
    parameter int LOAD_LAT = HAZ_LOAD_LAT,
    parameter int CNT_W    = HAZ_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    input  logic              id_kill_i,
    input  logic              pipe_hold_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic              id_branch_i,
    input  logic              id_wr_en_i,
    input  logic [REG_AW-1:0] id_wr_addr_i,
    input  logic              id_is_load_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic              issue_o,
`ifdef HAZ_PERF_SPLIT_EN
    output logic [31:0]       load_stall_cycles_o,
    output logic [31:0]       branch_stall_cycles_o,
`endif
    output logic [31:0]       stall_cycles_o
);
    localparam int NUM_REGS = 2**REG_AW;

    logic [NUM_REGS-1:0] rdy_alu, rdy_br;
    logic need_rs, need_rt, ok_rs, ok_rt, stall, cnt_en;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    assign rdy_alu[0] = 1'b1;
    assign rdy_br[0]  = 1'b1;

    for (genvar e = 1; e < NUM_REGS; e++) begin : g_ent
        hazard_scoreboard_unit_sb_entry #(
            .CNT_W(CNT_W), .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT)
        ) u_ent (
            .clk       (clk),
            .rst       (rst),
            .hold_i    (pipe_hold_i),
            .wr_i      (issue_o && id_wr_en_i && id_wr_addr_i == REG_AW'(e)),
            .is_load_i (id_is_load_i),
            .rdy_alu_o (rdy_alu[e]),
            .rdy_br_o  (rdy_br[e])
        );
    end

    // source readiness read against the pre-issue scoreboard, so self-dependence sees the old count
    always_comb begin
        need_rs = id_use_rs_i && id_rs_i != REG_AW'(HAZ_ZERO_REG);
        need_rt = id_use_rt_i && id_rt_i != REG_AW'(HAZ_ZERO_REG);
        ok_rs   = id_branch_i ? rdy_br[id_rs_i] : rdy_alu[id_rs_i];
        ok_rt   = id_branch_i ? rdy_br[id_rt_i] : rdy_alu[id_rt_i];
        stall   = id_valid_i && !id_kill_i && !rst && ((need_rs && !ok_rs) || (need_rt && !ok_rt));
        cnt_en  = stall && !pipe_hold_i;
        stall_cycles_d = sat_inc(stall_cycles_q, cnt_en);
    end

    assign stall_o        = stall;
    assign flush_o        = stall;
    assign issue_o        = id_valid_i && !id_kill_i && !stall && !pipe_hold_i;
    assign stall_cycles_o = stall_cycles_q;

    // total stall cycle counter
    always_ff @(posedge clk) begin
        if (rst) stall_cycles_q <= '0;
        else     stall_cycles_q <= stall_cycles_d;
    end

`ifdef HAZ_PERF_SPLIT_EN
    logic [31:0] ld_q, br_q;

    // stall cycles attributed to branch-compare or load/ALU consumers
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_q <= '0;
            br_q <= '0;
        end else begin
            ld_q <= sat_inc(ld_q, cnt_en && !id_branch_i);
            br_q <= sat_inc(br_q, cnt_en && id_branch_i);
        end
    end

    assign load_stall_cycles_o   = ld_q;
    assign branch_stall_cycles_o = br_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: directed scoreboard bench for the hazard scoreboard unit
module tb_hazard_scoreboard_unit;
    logic clk = 1'b0;
    logic rst, id_valid, id_kill, pipe_hold, id_use_rs, id_use_rt, id_branch, id_wr_en, id_is_load;
    logic [4:0] id_rs, id_rt, id_wr_addr;
    logic stall, flush, issue;
    logic [31:0] stall_cycles;
`ifdef HAZ_PERF_SPLIT_EN
    logic [31:0] load_stall_cycles, branch_stall_cycles;
`endif
    int checks = 0;
    int errors = 0;
    int exp_sc = 0;
    logic [1:0] q[$];

    always #5 clk = ~clk;

    hazard_scoreboard_unit dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid_i   (id_valid),
        .id_kill_i    (id_kill),
        .pipe_hold_i  (pipe_hold),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_use_rs_i  (id_use_rs),
        .id_use_rt_i  (id_use_rt),
        .id_branch_i  (id_branch),
        .id_wr_en_i   (id_wr_en),
        .id_wr_addr_i (id_wr_addr),
        .id_is_load_i (id_is_load),
        .stall_o      (stall),
        .flush_o      (flush),
        .issue_o      (issue),
`ifdef HAZ_PERF_SPLIT_EN
        .load_stall_cycles_o   (load_stall_cycles),
        .branch_stall_cycles_o (branch_stall_cycles),
`endif
        .stall_cycles_o (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic v, input logic k, input logic h,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                       input logic br, input logic we, input logic [4:0] wa, input logic ld,
                       input logic es, input logic ei);
        logic [1:0] e;
        id_valid = v; id_kill = k; pipe_hold = h;
        id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_branch = br; id_wr_en = we; id_wr_addr = wa; id_is_load = ld;
        q.push_back({es, ei});
        @(negedge clk);
        e = q.pop_front();
        chk({tag, ".stall"}, 32'(stall), 32'(e[1]));
        chk({tag, ".flush"}, 32'(flush), 32'(e[1]));
        chk({tag, ".issue"}, 32'(issue), 32'(e[0]));
        @(posedge clk);
        #1;
        if (es && !h) exp_sc++;
    endtask

    task automatic idle();
        cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alu(input string tag, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                       input logic es, input logic ei);
        cyc(tag, 1, 0, 0, rs, rt, 1, 1, 0, 1, rd, 0, es, ei);
    endtask

    task automatic lw(input string tag, input logic [4:0] rd);
        cyc(tag, 1, 0, 0, 5'd1, 5'd0, 1, 0, 0, 1, rd, 1, 0, 1);
    endtask

    task automatic beq(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                       input logic es, input logic ei);
        cyc(tag, 1, 0, 0, rs, rt, 1, 1, 1, 0, 5'd0, 0, es, ei);
    endtask

    initial begin
        rst = 1'b1;
        {id_valid, id_kill, pipe_hold, id_use_rs, id_use_rt, id_branch, id_wr_en, id_is_load} = '0;
        id_rs = '0; id_rt = '0; id_wr_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.stall", 32'(stall), 32'd0);
        chk("reset.issue", 32'(issue), 32'd0);
        chk("reset.stall_cycles", stall_cycles, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // ALU -> ALU back to back, then branch on the settled value
        alu("s1.add3", 5'd3, 5'd1, 5'd2, 0, 1);
        alu("s1.add4", 5'd4, 5'd3, 5'd3, 0, 1);
        beq("s1.beq3", 5'd3, 5'd0, 0, 1);
        idle(); idle();
        chk("s1.stall_cycles", stall_cycles, 32'(exp_sc));
        // load -> ALU: one stall
        lw("s2.lw5", 5'd5);
        alu("s2.add6a", 5'd6, 5'd5, 5'd0, 1, 0);
        alu("s2.add6b", 5'd6, 5'd5, 5'd0, 0, 1);
        chk("s2.stall_cycles", stall_cycles, 32'd1);
        idle(); idle();
        // load -> branch: two stalls; ALU -> branch: one stall
        lw("s3.lw5", 5'd5);
        beq("s3.beq5a", 5'd5, 5'd0, 1, 0);
        beq("s3.beq5b", 5'd5, 5'd0, 1, 0);
        beq("s3.beq5c", 5'd5, 5'd0, 0, 1);
        alu("s3.add7", 5'd7, 5'd1, 5'd2, 0, 1);
        beq("s3.beq7a", 5'd7, 5'd0, 1, 0);
        beq("s3.beq7b", 5'd7, 5'd0, 0, 1);
        chk("s3.stall_cycles", stall_cycles, 32'd4);
`ifdef HAZ_PERF_SPLIT_EN
        chk("s3.branch_stall_cycles", branch_stall_cycles, 32'd3);
        chk("s3.load_stall_cycles", load_stall_cycles, 32'd1);
`endif
        idle(); idle();
        // pipe_hold freezes the scoreboard and the stall counter
        lw("s4.lw8", 5'd8);
        repeat (4) cyc("s4.hold", 1, 0, 1, 5'd8, 5'd0, 1, 0, 0, 1, 5'd9, 0, 1, 0);
        chk("s4.hold_stall_cycles", stall_cycles, 32'd4);
        cyc("s4.rel_a", 1, 0, 0, 5'd8, 5'd0, 1, 0, 0, 1, 5'd9, 0, 1, 0);
        cyc("s4.rel_b", 1, 0, 0, 5'd8, 5'd0, 1, 0, 0, 1, 5'd9, 0, 0, 1);
        chk("s4.stall_cycles", stall_cycles, 32'd5);
        idle(); idle();
        // writes to $0 and killed producers leave the scoreboard untouched
        lw("s5.lw0", 5'd0);
        beq("s5.beq0", 5'd0, 5'd0, 0, 1);
        cyc("s5.kill", 1, 1, 0, 5'd1, 5'd0, 1, 0, 0, 1, 5'd11, 1, 0, 0);
        beq("s5.beq11", 5'd11, 5'd0, 0, 1);
        idle(); idle();
        // WAW: newest producer wins in both directions
        lw("s6.lw9", 5'd9);
        alu("s6.add9", 5'd9, 5'd1, 5'd2, 0, 1);
        alu("s6.rd9", 5'd12, 5'd9, 5'd0, 0, 1);
        idle(); idle();
        alu("s6.add13", 5'd13, 5'd1, 5'd2, 0, 1);
        lw("s6.lw13", 5'd13);
        alu("s6.rd13a", 5'd14, 5'd13, 5'd0, 1, 0);
        alu("s6.rd13b", 5'd14, 5'd13, 5'd0, 0, 1);
        chk("s6.stall_cycles", stall_cycles, 32'(exp_sc));
        // reset mid-operation clears pending entries and counters
        lw("s7.lw5", 5'd5);
        rst = 1'b1;
        cyc("s7.rst", 1, 0, 0, 5'd5, 5'd0, 1, 0, 0, 0, 5'd0, 0, 0, 1);
        rst = 1'b0;
        exp_sc = 0;
        chk("s7.stall_cycles", stall_cycles, 32'd0);
`ifdef HAZ_PERF_SPLIT_EN
        chk("s7.branch_stall_cycles", branch_stall_cycles, 32'd0);
`endif
        beq("s7.beq5", 5'd5, 5'd0, 0, 1);
        chk("s7.stall_cycles_end", stall_cycles, 32'(exp_sc));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
